// File: rtl/object_scanline_sequencer_pkg.sv
// Shared Mapache64 types for the object scanline path: OBM entry layout,
// sequencer state encoding and the per-line object cull test.
package mapache64;

  localparam int unsigned OBJ_X_W    = 9;
  localparam int unsigned OBJ_Y_W    = 8;
  localparam int unsigned OBJ_TILE_W = 8;
  localparam int unsigned OBJ_PAL_W  = 2;

  typedef struct packed {
    logic [OBJ_X_W-1:0]    x;
    logic [OBJ_Y_W-1:0]    y;
    logic [OBJ_TILE_W-1:0] tile;
    logic [OBJ_PAL_W-1:0]  palette;
    logic                  hflip;
    logic                  vflip;
  } obm_object_t;

  typedef enum logic [3:0] {
    SEQ_IDLE       = 4'd0,
    SEQ_CLEAR_REQ  = 4'd1,
    SEQ_CLEAR_WAIT = 4'd2,
    SEQ_FETCH      = 4'd3,
    SEQ_CHECK      = 4'd4,
    SEQ_LOAD_REQ   = 4'd5,
    SEQ_LOAD_WAIT  = 4'd6,
    SEQ_NEXT       = 4'd7,
    SEQ_DONE       = 4'd8
  } scan_seq_state_t;

  // An 8-line-tall object covers y when obj.y <= y <= obj.y+7, evaluated in
  // 9 bits so objects near the bottom never wrap onto the top lines.
  function automatic logic obj_on_line(input logic [OBJ_Y_W-1:0] y,
                                       input obm_object_t obj);
    logic [OBJ_Y_W:0] y9;
    logic [OBJ_Y_W:0] top9;
    y9   = {1'b0, y};
    top9 = {1'b0, obj.y};
    return (y9 >= top9) && (y9 <= top9 + 9'd7);
  endfunction

endpackage

// File: rtl/object_scanline_sequencer.sv
// Per-line object scanline sequencer: clears the scanline buffer for a new Y,
// then walks the OBM from the highest index down to 0 and loads every object
// covering that Y, so lower indices are written last and win overlaps.
module object_scanline_sequencer
  import mapache64::*;
#(
  parameter int unsigned NUM_OBJECTS = 64,
  localparam int unsigned IDX_W = $clog2(NUM_OBJECTS)
) (
  input  logic             gpu_clk,
  input  logic             rst,
  input  logic             line_start_i,
  input  logic [7:0]       line_y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             overrun_o,
  output logic [IDX_W-1:0] obm_addr_o,
  input  obm_object_t      obm_object_i,
  input  logic             scan_ready_i,
  output logic             scan_clear_start_o,
  output logic [7:0]       scan_new_y_o,
  output logic             scan_load_start_o,
  output obm_object_t      scan_load_object_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJECTS - 1);

  scan_seq_state_t  state_q;
  logic [IDX_W-1:0] index_q;
  logic [7:0]       y_q;
  obm_object_t      load_obj_q;

  // Sequencer FSM: state, OBM index, latched line Y and the held load object.
  always_ff @(posedge gpu_clk or posedge rst) begin
    if (rst) begin
      state_q    <= SEQ_IDLE;
      index_q    <= '0;
      y_q        <= '0;
      load_obj_q <= '0;
    end else begin
      case (state_q)
        SEQ_IDLE, SEQ_DONE: begin
          if (line_start_i) begin
            y_q     <= line_y_i;
            index_q <= LAST_IDX;
            state_q <= SEQ_CLEAR_REQ;
          end else begin
            state_q <= SEQ_IDLE;
          end
        end
        SEQ_CLEAR_REQ: begin
          if (scan_ready_i) state_q <= SEQ_CLEAR_WAIT;
        end
        SEQ_CLEAR_WAIT: begin
          if (scan_ready_i) state_q <= SEQ_FETCH;
        end
        SEQ_FETCH: begin
          state_q <= SEQ_CHECK;
        end
        SEQ_CHECK: begin
          if (obj_on_line(y_q, obm_object_i)) begin
            load_obj_q <= obm_object_i;
            state_q    <= SEQ_LOAD_REQ;
          end else begin
            state_q <= SEQ_NEXT;
          end
        end
        SEQ_LOAD_REQ: begin
          if (scan_ready_i) state_q <= SEQ_LOAD_WAIT;
        end
        SEQ_LOAD_WAIT: begin
          if (scan_ready_i) state_q <= SEQ_NEXT;
        end
        SEQ_NEXT: begin
          if (index_q == '0) begin
            state_q <= SEQ_DONE;
          end else begin
            index_q <= index_q - IDX_W'(1);
            state_q <= SEQ_FETCH;
          end
        end
        default: state_q <= SEQ_IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state; start pulses are qualified by the
  // buffer's ready in the same cycle so a request is never issued while busy.
  assign busy_o             = (state_q != SEQ_IDLE) && (state_q != SEQ_DONE);
  assign done_o             = (state_q == SEQ_DONE);
  assign overrun_o          = line_start_i && busy_o;
  assign obm_addr_o         = index_q;
  assign scan_new_y_o       = y_q;
  assign scan_clear_start_o = (state_q == SEQ_CLEAR_REQ) && scan_ready_i;
  assign scan_load_start_o  = (state_q == SEQ_LOAD_REQ) && scan_ready_i;
  assign scan_load_object_o = load_obj_q;

endmodule

// File: doc/object_scanline_sequencer.md
Name: object_scanline_sequencer

Overview:
Sequences one object_scanline buffer for each display line. On a line-start request it clears the buffer for the new Y. It then walks the object memory (OBM) from the highest index to index 0, culls objects that do not cover that Y, and issues a load for each object that does. Lower indices load last, so they win overlaps. It sits between the GPU line timing logic, the OBM read port and the scanline buffer.

Parameters:
NUM_OBJECTS, 64, number of OBM entries scanned; must be a power of two, at least 2.
IDX_W, $clog2(NUM_OBJECTS), OBM address width (derived; not overridden).

Ports:
gpu_clk  input  1  GPU clock; all state on the rising edge.
rst  input  1  asynchronous, active-high reset.
line_start_i  input  1  one-cycle request to build the buffer for line_y_i.
line_y_i  input  8  target scanline Y; sampled only when line_start_i is accepted.
busy_o  output  1  high from acceptance until done_o.
done_o  output  1  one-cycle pulse when the last object has been handled and the buffer is idle.
overrun_o  output  1  one-cycle pulse when line_start_i arrives while busy_o=1.
obm_addr_o  output  IDX_W  OBM read address.
obm_object_i  input  mapache64::obm_object_t  OBM read data, valid 1 cycle after obm_addr_o (synchronous read).
scan_ready_i  input  1  object_scanline ready_o.
scan_clear_start_o  output  1  to clear_start_i.
scan_new_y_o  output  8  to new_y_i.
scan_load_start_o  output  1  to load_start_i.
scan_load_object_o  output  mapache64::obm_object_t  to load_object_i; registered.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, all 1-bit outputs 0, obm_addr_o=0, scan_new_y_o=0, scan_load_object_o='0, index=0.
- The buffer has no reset. The sequencer therefore always clears before it loads; a line is never loaded without a preceding clear.
- IDLE: if line_start_i=1, latch y_q<=line_y_i, set index<=NUM_OBJECTS-1 and go to CLEAR_REQ. busy_o=1 from the next cycle.
- CLEAR_REQ: wait for scan_ready_i=1.
  - In that cycle, pulse scan_clear_start_o=1 and drive scan_new_y_o=y_q.
  - Go to CLEAR_WAIT.
- CLEAR_WAIT: wait for scan_ready_i=1. The buffer's ready is registered and is already low in this first cycle. Then go to FETCH.
- FETCH: drive obm_addr_o=index, then go to CHECK.
- CHECK: obm_object_i is valid in this cycle. Compute hit as a 9-bit unsigned test, with no wrap: {1'b0,y_q} >= {1'b0,obj.y} and {1'b0,y_q} <= {1'b0,obj.y}+9'd7.
  - If hit: register scan_load_object_o<=obm_object_i and go to LOAD_REQ.
  - If not hit: go to NEXT.
- LOAD_REQ: wait for scan_ready_i=1.
  - Pulse scan_load_start_o for exactly 1 cycle, then go to LOAD_WAIT.
  - scan_load_object_o must not change from CHECK until LOAD_WAIT exits; the buffer reads it combinationally throughout the load.
- LOAD_WAIT: wait for scan_ready_i=1, then go to NEXT.
- NEXT: if index==0, go to DONE; otherwise index<=index-1 and go to FETCH.
- DONE: done_o=1 for 1 cycle, busy_o=0 in that cycle, then return to IDLE.
  - A line_start_i in the DONE cycle is accepted exactly as in IDLE.
- Pulse discipline: scan_clear_start_o and scan_load_start_o are never high together. Neither is ever high while scan_ready_i=0. Each is high for at most 1 cycle per request.
- overrun_o: pulses for each cycle in which line_start_i=1 and state is neither IDLE nor DONE. The request is dropped and the current line continues unchanged.
- scan_new_y_o holds y_q from CLEAR_REQ until the next accepted line start. This keeps the buffer's display-valid compare stable.
- Timing with scan_ready_i held high between requests:
  - Clear phase takes 2 + 256 cycles.
  - Each miss object takes 3 cycles (FETCH, CHECK, NEXT).
  - Each hit object takes 3 + 2 + L cycles, where L is the buffer's load length (at most 8).

Decomposition:
- mapache64 package: reuse obm_object_t. Add a scan_seq_state_t enum (IDLE, CLEAR_REQ, CLEAR_WAIT, FETCH, CHECK, LOAD_REQ, LOAD_WAIT, NEXT, DONE).
- Add a package function obj_on_line(y, obj) for the 9-bit hit test, so the test is shared with the bench model.
- No sub-module; a single FSM with an index counter.

Test Plan:
- Reset asserted mid-load (state LOAD_WAIT): all outputs 0 immediately, asynchronously; after release, line_start_i with y=20 produces a clear before any load.
- All objects at y=200, line_y_i=10: one clear with scan_new_y_o=10, zero load pulses, done_o 2+256+3*64 cycles after acceptance (with an ideal ready model).
- Object 5 at (x=40,y=8) and object 2 at (x=44,y=10), line_y_i=12: loads issued in order 5 then 2; in the model, pixels 44..47 come from object 2 and pixels 40..43 from object 5.
- Object at y=250, line_y_i=1: no load (9-bit test, no wrap); object at y=250, line_y_i=255: loaded.
- line_start_i pulsed 100 cycles after acceptance: overrun_o=1 for 1 cycle, scan_new_y_o unchanged, single done_o.
- Randomized scan_ready_i stalls: no start pulse while ready=0, and scan_load_object_o stable from CHECK until LOAD_WAIT exit.
